// File: rtl/mix_sequencer_pkg.sv
// Shared definitions for the audio mix sequencer: FSM encoding, config register
// map, reset values and datapath widths.
package mix_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

  // Config register map
  localparam logic [1:0] AddrMask   = 2'd0;
  localparam logic [1:0] AddrPeriod = 2'd1;
  localparam logic [1:0] AddrShift  = 2'd2;
  localparam logic [1:0] AddrStatus = 2'd3;

  // Reset values
  localparam logic [7:0] MaskRst   = 8'hFF;
  localparam logic [7:0] PeriodRst = 8'd31;
  localparam logic [1:0] ShiftRst  = 2'd1;

  localparam int unsigned DacWidth = 9;
  localparam int unsigned AccWidth = 11;

  // Scale the accumulated sum and clamp it to the DAC range.
  function automatic logic [DacWidth-1:0] dac_sat(input logic [AccWidth-1:0] acc,
                                                  input logic [1:0]          sh);
    logic [AccWidth-1:0] scaled;
    scaled = acc >> sh;
    if (scaled > AccWidth'(511)) begin
      return {DacWidth{1'b1}};
    end
    return scaled[DacWidth-1:0];
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: 8-bit down-counter that reloads from period on reaching 0.
// A load forces the counter to period immediately; tick still follows the old count.
module sample_tick_gen
  import mix_sequencer_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] period,
  input  logic       load,
  output logic       tick
);

  logic [7:0] count_q, count_d;

  assign tick = (count_q == 8'd0);

  // Next count: explicit load, reload at zero, otherwise count down.
  always_comb begin
    count_d = count_q - 8'd1;
    if (load || tick) begin
      count_d = period;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= PeriodRst;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mix_sequencer.sv
// Audio mix sequencer: on each sample tick, scans NSLOT source slots through an
// external mux, sums the enabled ones, scales/saturates and presents the result
// to a sigma-delta DAC with a one-cycle strobe.
module mix_sequencer
  import mix_sequencer_pkg::*;
#(
  parameter int unsigned NSLOT = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [7:0]          cfg_din,
  output logic [7:0]          cfg_dout,
  output logic [2:0]          src_sel,
  input  logic [7:0]          src_data,
  output logic [DacWidth-1:0] dac_word,
  output logic                dac_strobe,
  output logic                busy
);

  localparam logic [2:0] LastSlot = 3'(NSLOT - 1);

  state_e                state_q, state_d;
  logic [7:0]            mask_q, mask_d;
  logic [7:0]            period_q, period_d;
  logic [1:0]            shift_q, shift_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            shadow_mask_q, shadow_mask_d;
  logic [1:0]            shadow_shift_q, shadow_shift_d;
  logic [AccWidth-1:0]   acc_q, acc_d, acc_next;
  logic [2:0]            src_sel_q, src_sel_d;
  logic [DacWidth-1:0]   dac_word_q, dac_word_d;
  logic                  dac_strobe_q, dac_strobe_d;

  logic                  period_wr;
  logic [7:0]            tick_period;
  logic                  tick;

  // A period write reloads the divider with the value being written.
  assign period_wr   = cfg_we && (cfg_addr == AddrPeriod);
  assign tick_period = period_wr ? cfg_din : period_q;

  sample_tick_gen u_tick (
    .Clk    (Clk),
    .Reset  (Reset),
    .period (tick_period),
    .load   (period_wr),
    .tick   (tick)
  );

  assign src_sel    = src_sel_q;
  assign dac_word   = dac_word_q;
  assign dac_strobe = dac_strobe_q;
  assign busy       = (state_q != StIdle);

  // Register read-back mux.
  always_comb begin
    cfg_dout = 8'h00;
    case (cfg_addr)
      AddrMask:   cfg_dout = mask_q;
      AddrPeriod: cfg_dout = period_q;
      AddrShift:  cfg_dout = {6'b0, shift_q};
      AddrStatus: cfg_dout = {7'b0, overrun_q};
      default:    cfg_dout = 8'h00;
    endcase
  end

  // Config register writes and sticky overrun flag; status write clears with priority.
  always_comb begin
    mask_d    = mask_q;
    period_d  = period_q;
    shift_d   = shift_q;
    overrun_d = overrun_q;
    if (tick && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
    if (cfg_we) begin
      case (cfg_addr)
        AddrMask:   mask_d    = cfg_din;
        AddrPeriod: period_d  = cfg_din;
        AddrShift:  shift_d   = cfg_din[1:0];
        AddrStatus: overrun_d = 1'b0;
        default:    ;
      endcase
    end
  end

  assign acc_next = acc_q + (shadow_mask_q[src_sel_q] ? {3'b000, src_data} : '0);

  // Scan FSM next-state and datapath. The DAC word is registered on the last
  // scan cycle so that it and the strobe are both visible during DONE.
  always_comb begin
    state_d        = state_q;
    shadow_mask_d  = shadow_mask_q;
    shadow_shift_d = shadow_shift_q;
    acc_d          = acc_q;
    src_sel_d      = src_sel_q;
    dac_word_d     = dac_word_q;
    dac_strobe_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d        = StScan;
          shadow_mask_d  = mask_q;
          shadow_shift_d = shift_q;
          acc_d          = '0;
          src_sel_d      = 3'd0;
        end
      end
      StScan: begin
        acc_d     = acc_next;
        src_sel_d = src_sel_q + 3'd1;
        if (src_sel_q == LastSlot) begin
          state_d      = StDone;
          src_sel_d    = 3'd0;
          dac_word_d   = dac_sat(acc_next, shadow_shift_q);
          dac_strobe_d = 1'b1;
        end
      end
      StDone: begin
        state_d   = StIdle;
        src_sel_d = 3'd0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; Reset also blocks config writes and aborts any scan.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= StIdle;
      mask_q         <= MaskRst;
      period_q       <= PeriodRst;
      shift_q        <= ShiftRst;
      overrun_q      <= 1'b0;
      shadow_mask_q  <= MaskRst;
      shadow_shift_q <= ShiftRst;
      acc_q          <= '0;
      src_sel_q      <= 3'd0;
      dac_word_q     <= '0;
      dac_strobe_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      period_q       <= period_d;
      shift_q        <= shift_d;
      overrun_q      <= overrun_d;
      shadow_mask_q  <= shadow_mask_d;
      shadow_shift_q <= shadow_shift_d;
      acc_q          <= acc_d;
      src_sel_q      <= src_sel_d;
      dac_word_q     <= dac_word_d;
      dac_strobe_q   <= dac_strobe_d;
    end
  end

endmodule
